ex_muldiv_hilo: RTL and testbench
=================================

# ex_muldiv_hilo

Execute-stage multiply/divide unit and HI/LO register pair. It is fed by the ID/EX pipeline buffer and performs MULT/MULTU/DIV/DIVU iteratively over multiple cycles, plus single-cycle MTHI/MTLO writes. It holds the architectural HI and LO registers. The hazard unit uses `busy_out` to stall dependent HI/LO instructions.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each WIDTH bits.
- `Clk`  in  1  rising-edge clock.
- `Rst_n`  in  1  reset: one clock; reset is asynchronous and active-low.
- `start_in`  in  1  op valid this cycle (from ID/EX hilowrite).
- `op_in`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (ignored).
- `rs_in`  in  WIDTH  operand A / dividend / MTHI-MTLO source.
- `rt_in`  in  WIDTH  operand B / divisor.
- `flush`  in  1  abort any in-flight operation.
- `busy_out`  out  1  high while an iterative op is in flight.
- `done_out`  out  1  one-cycle pulse when an iterative op has updated HI/LO.
- `hi_out`  out  WIDTH  HI register.
- `lo_out`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX. `busy_out` = (state != IDLE), decoded from the state register.
- Reset (`Rst_n` low, at any time, including mid-operation): state IDLE, `hi_out` = 0, `lo_out` = 0, `busy_out` = 0, `done_out` = 0, iteration counter = 0.
- IDLE + `start_in` + op 0–3:
  - latch operands; signed ops latch magnitudes and record the result signs;
  - go to RUN with counter 0.
- IDLE + `start_in` + op 4/5: write `rs_in` to HI (op 4) or LO (op 5) at that edge. State stays IDLE and `busy_out` stays 0.
- RUN: one iteration per edge, 32 iterations total; after the 32nd go to FIX.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per iteration.
- FIX: apply sign correction, write HI/LO, pulse `done_out`, return to IDLE.
- Results:
  - MULT/MULTU: {HI,LO} = full 64-bit product.
  - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
- Divide by zero (`rt_in` = 0): the op completes with normal timing and gives HI = `rs_in`, LO = all ones.
- `start_in` while busy: ignored; the hazard unit must stall.
- MTHI/MTLO while busy: also ignored.
- `flush`: forces IDLE and clears the counter. HI/LO keep their pre-op values and `done_out` does not pulse.
  - A simultaneous `start_in` is dropped.
  - `flush` in the FIX cycle also wins: no write occurs.
- Reserved opcodes: no state change.

## Timing
- Start sampled at edge E0. `busy_out` is high from after E0 through E33 (33 cycles).
- Iterations run at E1..E32. At E33 HI/LO are written, and `done_out` is high for the cycle following E33.
- Back-to-back: a new `start_in` can be accepted at E34, i.e. the cycle `busy_out` is low.
- MTHI/MTLO: the new value is visible on `hi_out`/`lo_out` the cycle after the sampling edge.
- All outputs are registered or decoded directly from state; there is no input-to-output combinational path.

## Configuration
- `MULDIV_DIV_EN` defined: divider datapath included; ops 2/3 behave as described above.
- `MULDIV_DIV_EN` undefined:
  - divider logic is removed; ops 2/3 are treated as reserved (ignored, no busy, HI/LO unchanged);
  - multiply, MTHI, MTLO and their timing are unchanged.

## Test plan
- Reset, then MULT with `rs_in` = 0xFFFFFFFF (-1) and `rt_in` = 2:
  - `busy_out` high for 33 cycles;
  - `done_out` pulse; HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- MULTU with `rs_in` = `rt_in` = 0xFFFFFFFF: HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV with `rs_in` = -7 and `rt_in` = 2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU with `rs_in` = 7 and `rt_in` = 0: HI = 7, LO = 0xFFFFFFFF.
- MTHI 0x1234 followed next cycle by MTLO 0x5678:
  - HI = 0x1234 and LO = 0x5678, each one cycle after its edge;
  - `busy_out` stays 0.
- MULT started, then `flush` at iteration 10: `busy_out` is 0 next cycle, HI/LO unchanged, no `done_out`. A MTLO issued during RUN is ignored.
- Assert `Rst_n` low mid-RUN: `busy_out` = 0, HI = LO = 0 immediately. Without `MULDIV_DIV_EN`, DIV leaves `busy_out` = 0 and HI/LO unchanged.

Source files
------------

// File: rtl/ex_muldiv_hilo.sv
// ex_muldiv_hilo: execute-stage iterative multiply/divide unit with the
// architectural HI/LO register pair. MULT/MULTU/DIV/DIVU run for WIDTH
// iterations plus one sign-fix cycle; MTHI/MTLO write in a single cycle.
// Optional feature macro: MULDIV_DIV_EN (includes the restoring divider;
// without it ops 2/3 are ignored like reserved opcodes).
//
// Handshake: start_in is a valid strobe with no ready. An op is taken only
// in a cycle where busy_out is low and flush is low; otherwise it is
// dropped, so the hazard unit must hold dependent HI/LO ops while busy_out
// is high. done_out pulses for exactly one cycle after HI/LO are written.
module ex_muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             start_in,
    input  logic [2:0]       op_in,
    input  logic [WIDTH-1:0] rs_in,
    input  logic [WIDTH-1:0] rt_in,
    input  logic             flush,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MULDIV_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q;      // mult: {partial hi, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]     opnd_q;     // multiplicand or divisor magnitude
    logic                 neg_lo_q;   // product / quotient must be negated
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 done_q;
`ifdef MULDIV_DIV_EN
    logic                 is_div_q;
    logic                 neg_hi_q;   // remainder follows dividend sign
    logic                 div_zero_q;
`endif

    logic                 is_mul_op;
    logic                 is_div_op;
    logic                 accept_iter;
    logic                 accept_mt;
    logic                 last_iter;
    logic                 rs_neg;
    logic                 rt_neg;
    logic [WIDTH-1:0]     rs_mag;
    logic [WIDTH-1:0]     rt_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     hi_fix;
    logic [WIDTH-1:0]     lo_fix;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
`endif

    // Decode the incoming op and form operand magnitudes for signed ops.
    always_comb begin
        is_mul_op = (op_in == OP_MULT) || (op_in == OP_MULTU);
`ifdef MULDIV_DIV_EN
        is_div_op = (op_in == OP_DIV) || (op_in == OP_DIVU);
`else
        is_div_op = 1'b0;
`endif
        accept_mt   = (state_q == S_IDLE) && start_in && !flush;
        accept_iter = accept_mt && (is_mul_op || is_div_op);
        // op bit 0 clear means signed (MULT, DIV)
        rs_neg = ~op_in[0] & rs_in[WIDTH-1];
        rt_neg = ~op_in[0] & rt_in[WIDTH-1];
        rs_mag = rs_neg ? -rs_in : rs_in;
        rt_mag = rt_neg ? -rt_in : rt_in;
        last_iter = (cnt_q == LAST_ITER);
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        acc_step = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (is_div_q) begin
            if (!div_trial[WIDTH]) begin
                acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod_fix = neg_lo_q ? -acc_q : acc_q;
        hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix   = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
            // divide by zero leaves the dividend as remainder and an all-ones quotient
            lo_fix = div_zero_q ? {WIDTH{1'b1}}
                   : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
            hi_fix = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
`endif
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything, including FIX.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept_iter) state_d = S_RUN;
                S_RUN:   if (last_iter) state_d = S_FIX;
                S_FIX:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: operand latch, iterations, HI/LO writes and done pulse.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            neg_lo_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                cnt_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept_mt && (op_in == OP_MTHI)) hi_q <= rs_in;
                        if (accept_mt && (op_in == OP_MTLO)) lo_q <= rs_in;
                        if (accept_iter) begin
                            cnt_q <= '0;
                            if (is_div_op) begin
                                acc_q  <= {{WIDTH{1'b0}}, rs_mag};
                                opnd_q <= rt_mag;
                            end else begin
                                acc_q  <= {{WIDTH{1'b0}}, rt_mag};
                                opnd_q <= rs_mag;
                            end
                            neg_lo_q <= rs_neg ^ rt_neg;
`ifdef MULDIV_DIV_EN
                            is_div_q   <= is_div_op;
                            neg_hi_q   <= rs_neg;
                            div_zero_q <= (rt_in == {WIDTH{1'b0}});
`endif
                        end
                    end
                    S_RUN: begin
                        acc_q <= acc_step;
                        cnt_q <= last_iter ? '0 : cnt_q + CW'(1);
                    end
                    S_FIX: begin
                        hi_q   <= hi_fix;
                        lo_q   <= lo_fix;
                        done_q <= 1'b1;
                    end
                    default: cnt_q <= '0;
                endcase
            end
        end
    end

    assign busy_out  = (state_q != S_IDLE);
    assign done_out  = done_q;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ex_muldiv_hilo.sv
// Bench for ex_muldiv_hilo: fixed vector table, hand-written multi-cycle
// sequences (flush, reset, MTHI/MTLO, busy start) and random ops checked
// against an arithmetic reference model.
module tb_ex_muldiv_hilo;

  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam int MAX_OP = 3;
`else
  localparam int MAX_OP = 1;
`endif

  logic         Clk;
  logic         Rst_n;
  logic         start_in;
  logic [2:0]   op_in;
  logic [W-1:0] rs_in;
  logic [W-1:0] rt_in;
  logic         flush;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;
  logic [1:0]   state_dbg;

  ex_muldiv_hilo #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .start_in  (start_in),
    .op_in     (op_in),
    .rs_in     (rs_in),
    .rt_in     (rt_in),
    .flush     (flush),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_hi;
  logic [W-1:0] model_lo;
  int n_pass;
  int n_total;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // reference model: {HI, LO} from plain arithmetic
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r = 64'd0;
    case (op)
      3'd0: r = 64'(sa * sb);
      3'd1: r = ua * ub;
      3'd2: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r = {sr[31:0], sq[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          r = {ur[31:0], uq[31:0]};
        end
      end
      default: r = {model_hi, model_lo};
    endcase
    return r;
  endfunction

  // wait for an accepted iterative op to finish; 'already' = busy cycles seen so far
  task automatic wait_done(input int already, input string name);
    int cyc;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
    cyc = already;
    while (busy_out === 1'b1 && cyc < 60) begin
      cyc++;
      @(negedge Clk);
    end
    check({name, " busy_cycles"}, 64'(cyc), 64'd33);
    check({name, " done"}, 64'(done_out), 64'd1);
    e_hi = exp_q.pop_front();
    e_lo = exp_q.pop_front();
    check({name, " hi"}, 64'(hi_out), 64'(e_hi));
    check({name, " lo"}, 64'(lo_out), 64'(e_lo));
    model_hi = e_hi;
    model_lo = e_lo;
  endtask

  // driver: called at a negedge, returns at the negedge where busy has dropped
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp, input string name);
    exp_q.push_back(exp[63:32]);
    exp_q.push_back(exp[31:0]);
    start_in = 1'b1;
    op_in = op;
    rs_in = a;
    rt_in = b;
    @(negedge Clk);
    start_in = 1'b0;
    wait_done(0, name);
  endtask

  task automatic mt_write(input logic [2:0] op, input logic [W-1:0] val, input string name);
    start_in = 1'b1;
    op_in = op;
    rs_in = val;
    @(negedge Clk);
    start_in = 1'b0;
    if (op == 3'd4) model_hi = val;
    else model_lo = val;
    check({name, " hi"}, 64'(hi_out), 64'(model_hi));
    check({name, " lo"}, 64'(lo_out), 64'(model_lo));
    check({name, " busy"}, 64'(busy_out), 64'd0);
  endtask

  // op that must be ignored (reserved, or divide without the divider)
  task automatic ignored_op(input logic [2:0] op, input string name);
    start_in = 1'b1;
    op_in = op;
    rs_in = 32'hFFFFFFF9;
    rt_in = 32'd2;
    @(negedge Clk);
    start_in = 1'b0;
    check({name, " busy"}, 64'(busy_out), 64'd0);
    repeat (3) @(negedge Clk);
    check({name, " hi"}, 64'(hi_out), 64'(model_hi));
    check({name, " lo"}, 64'(lo_out), 64'(model_lo));
    check({name, " done"}, 64'(done_out), 64'd0);
  endtask

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int sel;
    int pulses;

    n_pass = 0;
    n_total = 0;
    model_hi = '0;
    model_lo = '0;
    Rst_n = 1'b0;
    start_in = 1'b0;
    op_in = 3'd0;
    rs_in = '0;
    rt_in = '0;
    flush = 1'b0;

    // table of fixed vectors
    vecs.push_back('{3'd0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000});
    vecs.push_back('{3'd0, 32'd3,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1});
    vecs.push_back('{3'd0, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000});
`ifdef MULDIV_DIV_EN
    vecs.push_back('{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{3'd3, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF});
    vecs.push_back('{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF});
    vecs.push_back('{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E});
    vecs.push_back('{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
`endif

    // reset
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("reset hi", 64'(hi_out), 64'd0);
    check("reset lo", 64'(lo_out), 64'd0);
    check("reset busy", 64'(busy_out), 64'd0);
    check("reset done", 64'(done_out), 64'd0);
    check("reset state", 64'(state_dbg), 64'd0);

    // table vectors, issued back to back (each start lands on the cycle busy drops)
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo},
             $sformatf("vec%0d", i));
    end
    @(negedge Clk);
    check("done one cycle", 64'(done_out), 64'd0);

    // MTHI then MTLO on the next cycle
    mt_write(3'd4, 32'h00001234, "mthi");
    mt_write(3'd5, 32'h00005678, "mtlo");

    // flush at iteration 10 with a MTLO attempted during RUN
    start_in = 1'b1; op_in = 3'd0; rs_in = 32'd5; rt_in = 32'd6;
    @(negedge Clk);
    start_in = 1'b0;
    repeat (2) @(negedge Clk);
    start_in = 1'b1; op_in = 3'd5; rs_in = 32'hDEADBEEF;
    @(negedge Clk);
    start_in = 1'b0;
    repeat (6) @(negedge Clk);
    flush = 1'b1;
    @(negedge Clk);
    flush = 1'b0;
    check("flush busy", 64'(busy_out), 64'd0);
    check("flush hi", 64'(hi_out), 64'(model_hi));
    check("flush lo", 64'(lo_out), 64'(model_lo));
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_out === 1'b1) pulses++;
      @(negedge Clk);
    end
    check("flush no done", 64'(pulses), 64'd0);

    // flush during FIX suppresses the write
    start_in = 1'b1; op_in = 3'd1; rs_in = 32'd3; rt_in = 32'd4;
    @(negedge Clk);
    start_in = 1'b0;
    repeat (32) @(negedge Clk);
    check("fix state", 64'(state_dbg), 64'd2);
    flush = 1'b1;
    @(negedge Clk);
    flush = 1'b0;
    check("fixflush busy", 64'(busy_out), 64'd0);
    check("fixflush done", 64'(done_out), 64'd0);
    check("fixflush hi", 64'(hi_out), 64'(model_hi));
    check("fixflush lo", 64'(lo_out), 64'(model_lo));

    // start while busy is ignored; first op's result stands
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd6);
    start_in = 1'b1; op_in = 3'd0; rs_in = 32'd2; rt_in = 32'd3;
    @(negedge Clk);
    start_in = 1'b0;
    repeat (4) @(negedge Clk);
    start_in = 1'b1; op_in = 3'd1; rs_in = 32'd7; rt_in = 32'd7;
    @(negedge Clk);
    start_in = 1'b0;
    wait_done(5, "busy_start");

    // reserved opcode and (without the divider) DIV are ignored
    ignored_op(3'd6, "reserved6");
    ignored_op(3'd7, "reserved7");
`ifndef MULDIV_DIV_EN
    ignored_op(3'd2, "div_absent");
    ignored_op(3'd3, "divu_absent");
`endif

    // random ops against the reference model
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, MAX_OP));
      a = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFFFFFF;
        3: b = 32'($urandom_range(1, 100));
        default: b = $urandom;
      endcase
      run_op(op, a, b, ref_result(op, a, b), $sformatf("rand%0d_op%0d", i, op));
    end

    // asynchronous reset in the middle of RUN
    start_in = 1'b1; op_in = 3'd0; rs_in = 32'h00FF00FF; rt_in = 32'h00000777;
    @(negedge Clk);
    start_in = 1'b0;
    repeat (4) @(negedge Clk);
    check("prereset busy", 64'(busy_out), 64'd1);
    Rst_n = 1'b0;
    #1;
    model_hi = '0;
    model_lo = '0;
    check("midreset busy", 64'(busy_out), 64'd0);
    check("midreset hi", 64'(hi_out), 64'd0);
    check("midreset lo", 64'(lo_out), 64'd0);
    check("midreset state", 64'(state_dbg), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    run_op(3'd1, 32'd9, 32'd9, 64'd81, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
